// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral: oversampled SPI mode-0 target owning the PWM control register file.
// Optional readback on spi_cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5,
    parameter int FRAME_BITS  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_copi,
    input  logic       spi_ncs,
    output logic       spi_cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;
    localparam logic [6:0] NREGS = 7'(NUM_REGS);
    localparam logic [4:0] FBITS = 5'(FRAME_BITS);
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] sclk_q, copi_q, ncs_q;
    logic sclk_d, ncs_d, sclk_s, copi_s, ncs_s, sclk_rise, ncs_rise;
    logic [FRAME_BITS-1:0] sr;
    logic [4:0] cnt;
    logic [7:0] regs [NUM_REGS];
    logic [6:0] addr;
    logic do_write, do_err;
    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign copi_s    = copi_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign addr      = sr[FRAME_BITS-2:8];
    // ncs chain resets low so a frame already running at reset release is never seen as idle
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            copi_q <= '0;
            ncs_q  <= '0;
            sclk_d <= 1'b0;
            ncs_d  <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
            copi_q <= {copi_q[SYNC_STAGES-2:0], spi_copi};
            ncs_q  <= {ncs_q[SYNC_STAGES-2:0], spi_ncs};
            sclk_d <= sclk_s;
            ncs_d  <= ncs_s;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_nxt;
    end
    // IDLE uses the ncs level so a fall that happened during COMMIT is still taken
    always_comb begin
        state_nxt = (state == WAIT_IDLE) ? (ncs_s ? IDLE : WAIT_IDLE) :
                    (state == IDLE)      ? (ncs_s ? IDLE : SHIFT) :
                    (state == SHIFT)     ? (ncs_rise ? COMMIT : SHIFT) : IDLE;
    end
    always_comb begin
        do_write = (state == COMMIT) && (cnt == FBITS) && sr[FRAME_BITS-1] && (addr < NREGS);
        do_err   = (state == COMMIT) && (cnt != FBITS);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            cnt       <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= do_write;
            frame_err <= do_err;
            if (state == IDLE || state == WAIT_IDLE) begin
                sr  <= '0;
                cnt <= '0;
            end else if (state == SHIFT && sclk_rise) begin
                sr  <= {sr[FRAME_BITS-2:0], copi_s};
                cnt <= (cnt == 5'd31) ? cnt : cnt + 5'd1;
            end
            for (int i = 0; i < NUM_REGS; i++)
                if (do_write && addr == 7'(i)) regs[i] <= sr[7:0];
        end
    end
    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];
`ifdef SPI_READBACK_EN
    logic sclk_fall;
    logic [7:0] rd_data, rd_shift;
    assign sclk_fall = ~sclk_s & sclk_d;
    // after the 8th rise the low byte of sr is exactly the R/W + address header
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (!sr[7] && sr[6:0] == 7'(i)) rd_data = regs[i];
    end
    always_ff @(posedge clk) begin
        if (rst || state != SHIFT) begin
            spi_cipo <= 1'b0;
            rd_shift <= '0;
        end else if (sclk_fall) begin
            if (cnt == 5'd8) begin
                spi_cipo <= rd_data[7];
                rd_shift <= {rd_data[6:0], 1'b0};
            end else if (cnt > 5'd8 && cnt < FBITS) begin
                spi_cipo <= rd_shift[7];
                rd_shift <= {rd_shift[6:0], 1'b0};
            end else begin
                spi_cipo <= 1'b0;
            end
        end
    end
`else
    assign spi_cipo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb_spi_reg_peripheral: table-driven and randomized frames checked against a register-file model.
module tb_spi_reg_peripheral;
    localparam int HP = 6;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic spi_sclk = 1'b0, spi_copi = 1'b0, spi_ncs = 1'b1;
    logic spi_cipo, wr_strobe, frame_err;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    int total = 0, bad = 0, wr_cnt = 0, err_cnt = 0, exp_wr = 0, exp_err = 0;
    logic [7:0] model [5];
    always #5 clk = ~clk;
    spi_reg_peripheral dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_copi(spi_copi), .spi_ncs(spi_ncs),
        .spi_cipo(spi_cipo), .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
    );
    always @(posedge clk) begin
        if (wr_strobe) wr_cnt <= wr_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    typedef struct {
        logic [31:0] frame;
        int          nbits;
        int          idx;
        logic [7:0]  val;
        int          d_wr;
        int          d_err;
    } vec_t;
    vec_t vecs [8];
    function automatic logic [7:0] get_reg(input int i);
        case (i)
            0: return en_reg_out_7_0;
            1: return en_reg_out_15_8;
            2: return en_reg_pwm_7_0;
            3: return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [7:0] exp_rx(input logic [31:0] f, input int n);
        if (RB && n == 16 && !f[15] && f[14:8] < 5) return model[f[14:8]];
        return 8'h00;
    endfunction
    task automatic apply_model(input logic [31:0] f, input int n);
        if (n != 16) exp_err++;
        else if (f[15] && f[14:8] < 5) begin
            model[f[14:8]] = f[7:0];
            exp_wr++;
        end
    endtask
    task automatic check_all(input string tag);
        for (int i = 0; i < 5; i++) check($sformatf("%s reg%0d", tag, i), get_reg(i), model[i]);
        check({tag, " strobes"}, wr_cnt, exp_wr);
        check({tag, " errors"}, err_cnt, exp_err);
    endtask
    task automatic spi_frame(input logic [31:0] f, input int n, input bit raise, output logic [31:0] rx);
        rx = '0;
        @(negedge clk) spi_ncs = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            spi_copi = f[i];
            repeat (HP) @(negedge clk);
            rx = {rx[30:0], spi_cipo};
            spi_sclk = 1'b1;
            repeat (HP) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (HP) @(negedge clk);
        if (raise) begin
            spi_ncs = 1'b1;
            repeat (12) @(negedge clk);
        end
    endtask
    initial begin
        logic [31:0] f, rx;
        logic [7:0] erx;
        int n, bw, be;
        vecs[0] = '{32'h8480,  16, 4, 8'h80, 1, 0};
        vecs[1] = '{32'h80F0,  16, 0, 8'hF0, 1, 0};
        vecs[2] = '{32'h83A5,  16, 3, 8'hA5, 1, 0};
        vecs[3] = '{32'h4011,  15, 0, 8'hF0, 0, 1};
        vecs[4] = '{32'h10123, 17, 0, 8'hF0, 0, 1};
        vecs[5] = '{32'h8755,  16, 0, 8'hF0, 0, 0};
        vecs[6] = '{32'h813C,  16, 1, 8'h3C, 1, 0};
        vecs[7] = '{32'h0100,  16, 1, 8'h3C, 0, 0};
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_all("reset");
        check("reset wr_strobe", wr_strobe, 0);
        check("reset frame_err", frame_err, 0);
        check("reset cipo", spi_cipo, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            spi_sclk = 1'b1;
            repeat (HP) @(negedge clk);
            spi_sclk = 1'b0;
            repeat (HP) @(negedge clk);
        end
        check_all("sclk_ncs_high");
        foreach (vecs[k]) begin
            bw = wr_cnt;
            be = err_cnt;
            erx = exp_rx(vecs[k].frame, vecs[k].nbits);
            spi_frame(vecs[k].frame, vecs[k].nbits, 1'b1, rx);
            apply_model(vecs[k].frame, vecs[k].nbits);
            check($sformatf("vec%0d reg", k), get_reg(vecs[k].idx), vecs[k].val);
            check($sformatf("vec%0d strobe", k), wr_cnt - bw, vecs[k].d_wr);
            check($sformatf("vec%0d err", k), err_cnt - be, vecs[k].d_err);
            if (vecs[k].nbits == 16) check($sformatf("vec%0d cipo", k), rx[7:0], erx);
            check_all($sformatf("vec%0d", k));
        end
        // commit latency: write lands on the 4th clk edge after the raw ncs rise
        spi_frame(32'h8442, 16, 1'b0, rx);
        @(negedge clk) spi_ncs = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("latency early duty", pwm_duty_cycle, model[4]);
        check("latency early strobe", wr_strobe, 0);
        @(posedge clk);
        #1 check("latency duty", pwm_duty_cycle, 8'h42);
        check("latency strobe", wr_strobe, 1);
        @(posedge clk);
        #1 check("latency strobe pulse", wr_strobe, 0);
        apply_model(32'h8442, 16);
        repeat (12) @(negedge clk);
        check_all("latency");
        // reset in the middle of a frame, ncs still low at release
        spi_frame(32'h82, 8, 1'b0, rx);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        spi_frame(32'hFF, 8, 1'b1, rx);
        check_all("midreset");
        spi_frame(32'h8211, 16, 1'b1, rx);
        apply_model(32'h8211, 16);
        check("midreset pwm_7_0", en_reg_pwm_7_0, 8'h11);
        check_all("after_midreset");
        for (int k = 0; k < 40; k++) begin
            n = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? 15 : 17) : 16;
            f = {$urandom_range(0, 3) != 0, 7'($urandom_range(0, 7)), 8'($urandom)};
            if (n == 15) f = f >> 1;
            if (n == 17) f = {f[15:0], 1'b1};
            erx = exp_rx(f, n);
            spi_frame(f, n, 1'b1, rx);
            apply_model(f, n);
            if (n == 16) check($sformatf("rand%0d cipo", k), rx[7:0], erx);
            check_all($sformatf("rand%0d", k));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
